// File: rtl/reel_control_param.sv
// rtl/reel_control_param.sv - reel motor direction control with homing, dwell, deadband and length clamp
module reel_control_param #(
    parameter int LEN_W        = 32,
    parameter int DIST_W       = 40,
    parameter int SCALE        = 10000000,
    parameter int STEP         = 500,
    parameter int MAX_LEN      = 50,
    parameter int DEADBAND     = 0,
    parameter int REV_DWELL    = 1000,
    parameter int HOME_TIMEOUT = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              toggle,
    input  logic              proximity_out,
    input  logic [3:0]        num,
    input  logic [DIST_W-1:0] distance,
    input  logic              rehome,
    output logic [1:0]        dir,
    output logic [LEN_W-1:0]  dist_test,
    output logic [LEN_W-1:0]  leng_test,
    output logic              homed,
    output logic              at_target,
    output logic              fault
);
    localparam int DW_W = $clog2(REV_DWELL + 1);
    localparam int TO_W = $clog2(HOME_TIMEOUT + 1);

    localparam logic [1:0]        DIR_STOP = 2'b00;
    localparam logic [1:0]        DIR_RET  = 2'b10;
    localparam logic [1:0]        DIR_EXT  = 2'b11;
    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
    localparam logic [LEN_W-1:0]  STEP_L   = LEN_W'(STEP);
    localparam logic [LEN_W-1:0]  MAX_L    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  SCALE_L  = LEN_W'(SCALE);
    localparam logic [LEN_W:0]    DB_X     = (LEN_W + 1)'(DEADBAND);
    localparam logic [DIST_W-1:0] SCALE_D  = DIST_W'(SCALE);
    localparam logic [DIST_W-1:0] MAX_D    = DIST_W'(MAX_LEN);
    localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(REV_DWELL - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(HOME_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOMING, S_IDLE, S_EXTEND, S_RETRACT, S_DWELL, S_FAULT
    } state_t;

    state_t            state_q;
    logic [1:0]        dir_q;
    logic [LEN_W-1:0]  length_q, length_d;
    logic              homed_q, fault_q;
    logic [DW_W-1:0]   dwell_q;
    logic [TO_W-1:0]   tmo_q;

    logic [DIST_W-1:0] dist_full;
    logic [LEN_W-1:0]  leng_s, tgt;
    logic [LEN_W:0]    leng_x, tgt_x;
    logic [1:0]        auto_req, man_req, raw_req, req;

    assign dist_full = distance / SCALE_D;
    assign dist_test = LEN_W'(dist_full);
    assign leng_s    = length_q / SCALE_L;
    assign leng_test = leng_s;
    assign tgt       = (dist_full > MAX_D) ? MAX_L : LEN_W'(dist_full);
    assign leng_x    = {1'b0, leng_s};
    assign tgt_x     = {1'b0, tgt};

    always_comb begin
        auto_req = DIR_STOP;
        if (leng_x + DB_X < tgt_x)
            auto_req = DIR_EXT;
        else if (leng_x > tgt_x + DB_X)
            auto_req = DIR_RET;
    end

    always_comb begin
        man_req = DIR_STOP;
        if (num == 4'd10)
            man_req = DIR_RET;
        else if (num == 4'd11)
            man_req = DIR_EXT;
    end

    // Interlocks guard both modes: never drive into the home stop or past the clamp.
    always_comb begin
        raw_req = toggle ? man_req : auto_req;
        req     = raw_req;
        if (raw_req == DIR_RET && !proximity_out)
            req = DIR_STOP;
        if (raw_req == DIR_EXT && leng_s >= MAX_L)
            req = DIR_STOP;
    end

    // Dead reckoning from the direction actually applied last cycle.
    always_comb begin
        length_d = length_q;
        if (!proximity_out)
            length_d = '0;
        else if (dir_q == DIR_EXT)
            length_d = (length_q > LEN_MAX - STEP_L) ? LEN_MAX : length_q + STEP_L;
        else if (dir_q == DIR_RET)
            length_d = (length_q < STEP_L) ? '0 : length_q - STEP_L;
    end

    function automatic state_t motion_state(input logic [1:0] r);
        case (r)
            DIR_EXT: motion_state = S_EXTEND;
            DIR_RET: motion_state = S_RETRACT;
            default: motion_state = S_IDLE;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_HOMING;
            dir_q    <= DIR_STOP;
            length_q <= '0;
            homed_q  <= 1'b0;
            fault_q  <= 1'b0;
            dwell_q  <= '0;
            tmo_q    <= '0;
        end else begin
            length_q <= length_d;
            if (state_q == S_FAULT) begin
                dir_q   <= DIR_STOP;
                homed_q <= 1'b0;
                fault_q <= 1'b1;
            end else if (rehome) begin
                state_q <= S_HOMING;
                dir_q   <= DIR_RET;
                homed_q <= 1'b0;
                tmo_q   <= '0;
            end else begin
                case (state_q)
                    S_HOMING: begin
                        if (!proximity_out) begin
                            state_q <= S_IDLE;
                            dir_q   <= DIR_STOP;
                            homed_q <= 1'b1;
                        end else if (tmo_q == TO_LAST) begin
                            state_q <= S_FAULT;
                            dir_q   <= DIR_STOP;
                            fault_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + TO_W'(1);
                            dir_q <= DIR_RET;
                        end
                    end
                    S_IDLE: begin
                        state_q <= motion_state(req);
                        dir_q   <= req;
                    end
                    S_EXTEND, S_RETRACT: begin
                        if (req == DIR_STOP) begin
                            state_q <= S_IDLE;
                            dir_q   <= DIR_STOP;
                        end else if (req != dir_q) begin
                            state_q <= S_DWELL;
                            dir_q   <= DIR_STOP;
                            dwell_q <= '0;
                        end
                    end
                    S_DWELL: begin
                        if (dwell_q == DW_LAST) begin
                            state_q <= motion_state(req);
                            dir_q   <= req;
                        end else begin
                            dwell_q <= dwell_q + DW_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_HOMING;
                        dir_q   <= DIR_STOP;
                    end
                endcase
            end
        end
    end

    assign dir       = dir_q;
    assign homed     = homed_q;
    assign fault     = fault_q;
    assign at_target = !toggle && homed_q && (state_q != S_HOMING) && (auto_req == DIR_STOP);

endmodule
